// File: rtl/consmax_lut_loader_pkg.sv
// Shared constants, FSM state encoding and FP entry layout for the ConSmax LUT loader.
package consmax_lut_loader_pkg;
    localparam int GBUS_DATA = 64;
    localparam int IDATA_BIT = 8;
    localparam int EXP_BIT   = 8;
    localparam int MAT_BIT   = 7;
    localparam int LUT_DATA  = EXP_BIT + MAT_BIT + 1;
    localparam int LUT_ADDR  = IDATA_BIT >> 1;
    localparam int LUT_DEPTH = 2 ** LUT_ADDR;

    // K entries per bus word; TOTAL entries span both LUT banks.
    localparam int K       = GBUS_DATA / LUT_DATA;
    localparam int TOTAL   = 2 * LUT_DEPTH;
    localparam int LANE_W  = (K > 1) ? $clog2(K) : 1;
    localparam int ENTRY_W = LUT_ADDR + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic               sign;
        logic [EXP_BIT-1:0] expo;
        logic [MAT_BIT-1:0] mant;
    } fp_entry_t;
endpackage

// File: rtl/consmax_lut_unpack.sv
// Word buffer plus lane mux; a word being loaded this cycle bypasses to lane 0.
module consmax_lut_unpack
    import consmax_lut_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [GBUS_DATA-1:0] in_data,
    input  logic [LANE_W-1:0]    sel,
    output logic [LUT_DATA-1:0]  entry
);
    logic [GBUS_DATA-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (load) word_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end

    always_comb begin
        entry = word_q[sel*LUT_DATA +: LUT_DATA];
        if (load) entry = in_data[LUT_DATA-1:0];
    end
endmodule

// File: rtl/consmax_lut_loader.sv
// ConSmax LUT loader: fetches packed LUT words over valid/ready and streams single-entry
// writes across both banks. Define CONSMAX_LUT_CHECKSUM_EN to add the lut_checksum port.
module consmax_lut_loader
    import consmax_lut_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           cfg_shift_in,
    input  logic [GBUS_DATA-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [LUT_ADDR:0]    lut_waddr,
    output logic                 lut_wen,
    output logic [LUT_DATA-1:0]  lut_wdata,
    output logic [7:0]           cfg_consmax_shift,
    output logic                 busy,
    output logic                 done
`ifdef CONSMAX_LUT_CHECKSUM_EN
    ,
    output logic [LUT_DATA-1:0]  lut_checksum
`endif
);
    logic [1:0]          state_q, state_d;
    logic [ENTRY_W-1:0]  entry_q, entry_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                in_ready_q, in_ready_d;
    logic                lut_wen_q, lut_wen_d;
    logic [LUT_ADDR:0]   lut_waddr_q, lut_waddr_d;
    logic [LUT_DATA-1:0] lut_wdata_q, lut_wdata_d;
    logic [7:0]          shift_q, shift_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_hit, abort_hit, accept, last_lane;
    logic [LUT_DATA-1:0] unpack_entry;
    fp_entry_t           lane_entry;

    assign start_hit  = (state_q == ST_IDLE) && start && !abort;
    assign abort_hit  = (state_q != ST_IDLE) && abort;
    assign accept     = (state_q == ST_FETCH) && in_valid && in_ready_q && !abort;
    assign last_lane  = (lane_q == LANE_W'(K - 1));
    assign lane_entry = fp_entry_t'(unpack_entry);

    consmax_lut_unpack u_unpack (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .in_data (in_data),
        .sel     (lane_d),
        .entry   (unpack_entry)
    );

    // Output registers are loaded from the next-state view, so each write is visible
    // in the same cycle the FSM sits in WRITE for it.
    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        lane_d      = lane_q;
        shift_d     = shift_q;
        lut_waddr_d = lut_waddr_q;
        lut_wdata_d = lut_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start_hit) begin
                    state_d = ST_FETCH;
                    shift_d = cfg_shift_in;
                    entry_d = '0;
                    lane_d  = '0;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    state_d = ST_WRITE;
                    lane_d  = '0;
                end
            end
            ST_WRITE: begin
                entry_d = entry_q + ENTRY_W'(1);
                lane_d  = lane_q + LANE_W'(1);
                if (last_lane)
                    state_d = (entry_q == ENTRY_W'(TOTAL - 1)) ? ST_DONE : ST_FETCH;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
            entry_d = '0;
            lane_d  = '0;
        end
        if (state_d == ST_WRITE) begin
            lut_waddr_d = entry_d[LUT_ADDR:0];
            lut_wdata_d = lane_entry;
        end
        in_ready_d = (state_d == ST_FETCH);
        lut_wen_d  = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            entry_q     <= '0;
            lane_q      <= '0;
            in_ready_q  <= 1'b0;
            lut_wen_q   <= 1'b0;
            lut_waddr_q <= '0;
            lut_wdata_q <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            lane_q      <= lane_d;
            in_ready_q  <= in_ready_d;
            lut_wen_q   <= lut_wen_d;
            lut_waddr_q <= lut_waddr_d;
            lut_wdata_q <= lut_wdata_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign lut_wen           = lut_wen_q;
    assign lut_waddr         = lut_waddr_q;
    assign lut_wdata         = lut_wdata_q;
    assign cfg_consmax_shift = shift_q;
    assign busy              = busy_q;
    assign done              = done_q;

`ifdef CONSMAX_LUT_CHECKSUM_EN
    // Sums the writes already presented, so the total for the load lands with done.
    logic [LUT_DATA-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (lut_wen_q)             checksum_d = checksum_q + lut_wdata_q;
        if (start_hit || abort_hit) checksum_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign lut_checksum = checksum_q;
`endif
endmodule

// File: tb/tb_consmax_lut_loader.sv
// Self-checking bench for consmax_lut_loader: transaction-level reference model checked
// every cycle, plus directed literal checks. Honours CONSMAX_LUT_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_consmax_lut_loader;
    import consmax_lut_loader_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n, start, abort, in_valid;
    logic [7:0]           cfg_shift_in;
    logic [GBUS_DATA-1:0] in_data;
    logic                 in_ready, lut_wen, busy, done;
    logic [LUT_ADDR:0]    lut_waddr;
    logic [LUT_DATA-1:0]  lut_wdata;
    logic [7:0]           cfg_consmax_shift;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [LUT_DATA-1:0]  lut_checksum;
`endif

    consmax_lut_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
        .cfg_shift_in      (cfg_shift_in),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .lut_waddr         (lut_waddr),
        .lut_wen           (lut_wen),
        .lut_wdata         (lut_wdata),
        .cfg_consmax_shift (cfg_consmax_shift),
        .busy              (busy),
        .done              (done)
`ifdef CONSMAX_LUT_CHECKSUM_EN
        ,
        .lut_checksum      (lut_checksum)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cycle_cnt = 0;
    int t0        = 0;

    logic [GBUS_DATA-1:0] src_q[$];
    logic [LUT_DATA-1:0]  exp_data [TOTAL];
    int                   log_addr[$];
    int                   log_data[$];
    int                   sent = 0, stall_at = -1, stall_left = 0;
    bit                   gaps = 1'b0;

    // Reference model: tracks the load as "words fetched / entries left in this word".
    bit                  m_busy = 0, m_ready = 0, m_wen = 0, m_done = 0;
    logic [LUT_ADDR:0]   m_waddr = '0;
    logic [LUT_DATA-1:0] m_wdata = '0, m_sum = '0;
    logic [7:0]          m_shift = '0;
    logic [LUT_DATA-1:0] m_word [K];
    int                  m_pend = 0, m_next = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    endtask

    task automatic model_emit();
        m_wen   = 1'b1;
        m_waddr = m_next[LUT_ADDR:0];
        m_wdata = m_word[K - m_pend];
        m_next++;
        m_pend--;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_ready = 0; m_wen = 0; m_done = 0;
            m_waddr = '0; m_wdata = '0; m_shift = '0; m_sum = '0;
            m_pend = 0; m_next = 0;
        end else if (abort && m_busy) begin
            m_busy = 0; m_ready = 0; m_wen = 0; m_done = 0;
            m_sum = '0; m_pend = 0; m_next = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_ready = 1; m_shift = cfg_shift_in;
                m_sum = '0; m_next = 0;
            end
        end else begin
            if (m_wen) m_sum = m_sum + m_wdata;
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (m_ready) begin
                if (in_valid) begin
                    for (int i = 0; i < K; i++) m_word[i] = in_data[i*LUT_DATA +: LUT_DATA];
                    m_ready = 0;
                    m_pend  = K;
                    model_emit();
                end
            end else if (m_pend > 0) begin
                model_emit();
            end else begin
                m_wen = 0;
                if (m_next == TOTAL) m_done = 1;
                else                 m_ready = 1;
            end
        end
    end

    always @(negedge clk) begin
        check_output("in_ready", in_ready, m_ready);
        check_output("lut_wen", lut_wen, m_wen);
        check_output("busy", busy, m_busy);
        check_output("done", done, m_done);
        check_output("cfg_shift", cfg_consmax_shift, m_shift);
        if (m_wen) begin
            check_output("lut_waddr", lut_waddr, m_waddr);
            check_output("lut_wdata", lut_wdata, m_wdata);
        end
`ifdef CONSMAX_LUT_CHECKSUM_EN
        check_output("lut_checksum", lut_checksum, m_sum);
`endif
        if (lut_wen) begin
            log_addr.push_back(int'(lut_waddr));
            log_data.push_back(int'(lut_wdata));
        end
    end

    // One cycle; acts as a valid/ready source that holds an unaccepted word.
    task automatic apply_stimulus();
        bit acc;
        acc = in_valid && in_ready && rst_n && !abort;
        @(negedge clk);
        cycle_cnt++;
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        if (acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            sent++;
            if (sent == stall_at) stall_left = 3;
        end
        if (in_valid && !acc && src_q.size() > 0) begin
        end else if (src_q.size() == 0) begin
            in_valid = 1'b0;
        end else if (stall_left > 0) begin
            in_valid = 1'b0;
            if (in_ready) stall_left--;
        end else if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_data  = src_q[0];
        end
    endtask

    task automatic fill_source(input bit rnd);
        logic [GBUS_DATA-1:0] word;
        logic [LUT_DATA-1:0]  e;
        src_q.delete();
        sent = 0;
        for (int w = 0; w < TOTAL / K; w++) begin
            word = '0;
            for (int l = 0; l < K; l++) begin
                e = rnd ? LUT_DATA'($urandom) : LUT_DATA'(32'h3F00 + w*K + l);
                exp_data[w*K + l] = e;
                word[l*LUT_DATA +: LUT_DATA] = e;
            end
            src_q.push_back(word);
        end
    endtask

    task automatic launch(input string name, input logic [7:0] shift);
        log_addr.delete();
        log_data.delete();
        cfg_shift_in = shift;
        start = 1'b1;
        t0 = cycle_cnt;
        apply_stimulus();
        check_output(name, cfg_consmax_shift, shift);
    endtask

    task automatic wait_write(input string name, input int addr);
        int n = 0;
        while (!(lut_wen && int'(lut_waddr) == addr) && n < 300) begin
            apply_stimulus();
            n++;
        end
        check_output(name, n < 300, 1);
    endtask

    task automatic wait_done(input string name, output int lat);
        int n = 0;
        while (!done && n < 400) begin
            apply_stimulus();
            n++;
        end
        lat = done ? (cycle_cnt - t0) : -1;
        check_output(name, done, 1);
    endtask

    task automatic finish_load(input string name);
        apply_stimulus();
        check_output(name, busy, 0);
    endtask

    task automatic check_seq(input string name);
        int errs = 0;
        if (log_addr.size() != TOTAL) errs++;
        for (int i = 0; i < TOTAL && i < log_addr.size(); i++) begin
            if (log_addr[i] != i) errs++;
            if (log_data[i] != int'(exp_data[i])) errs++;
        end
        check_output(name, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_shift_in = '0; in_valid = 1'b0; in_data = '0;
        apply_stimulus();
        check_output("rst_in_ready", in_ready, 0);
        check_output("rst_lut_wen", lut_wen, 0);
        check_output("rst_lut_waddr", lut_waddr, 0);
        check_output("rst_lut_wdata", lut_wdata, 0);
        check_output("rst_cfg_shift", cfg_consmax_shift, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        apply_stimulus();

        // Nominal load with the incrementing 3F00 pattern.
        fill_source(1'b0);
        launch("nom_shift", 8'h05);
        wait_done("nom_done_seen", lat);
        check_output("nom_latency", lat, 41);
`ifdef CONSMAX_LUT_CHECKSUM_EN
        check_output("nom_checksum", lut_checksum, 16'hE1F0);
`endif
        check_seq("nom_seq");
        finish_load("nom_busy_after");

        // Three idle FETCH cycles before word 4.
        fill_source(1'b0);
        stall_at = 3;
        launch("bp_shift", 8'h05);
        wait_done("bp_done_seen", lat);
        check_output("bp_latency", lat, 44);
        check_seq("bp_seq");
        finish_load("bp_busy_after");
        stall_at = -1;

        // Abort while address 13 is on the write port, then restart from scratch.
        fill_source(1'b0);
        launch("ab_shift", 8'h05);
        wait_write("ab_reach13", 13);
        abort = 1'b1;
        src_q.delete();
        in_valid = 1'b0;
        apply_stimulus();
        check_output("ab_wen", lut_wen, 0);
        check_output("ab_busy", busy, 0);
        check_output("ab_cfg_kept", cfg_consmax_shift, 8'h05);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_output("ab_no_done", done, 0);
        end
        fill_source(1'b0);
        launch("ab_re_shift", 8'h05);
        wait_done("ab_re_done_seen", lat);
        check_output("ab_re_latency", lat, 41);
        check_seq("ab_re_seq");
        finish_load("ab_re_busy_after");

        // Start pulse mid-load must be ignored.
        fill_source(1'b0);
        launch("sb_shift", 8'h05);
        wait_write("sb_reach7", 7);
        cfg_shift_in = 8'h09;
        start = 1'b1;
        apply_stimulus();
        check_output("sb_cfg_kept", cfg_consmax_shift, 8'h05);
        wait_done("sb_done_seen", lat);
        check_output("sb_latency", lat, 41);
        check_seq("sb_seq");
        finish_load("sb_busy_after");

        // Reset pulse at address 20.
        fill_source(1'b0);
        launch("rm_shift", 8'h05);
        wait_write("rm_reach20", 20);
        rst_n = 1'b0;
        src_q.delete();
        in_valid = 1'b0;
        apply_stimulus();
        check_output("rm_in_ready", in_ready, 0);
        check_output("rm_lut_wen", lut_wen, 0);
        check_output("rm_lut_waddr", lut_waddr, 0);
        check_output("rm_lut_wdata", lut_wdata, 0);
        check_output("rm_cfg_shift", cfg_consmax_shift, 0);
        check_output("rm_busy", busy, 0);
        apply_stimulus();
        check_output("rm_idle", busy, 0);

        // Random data, random source gaps, random shift values.
        gaps = 1'b1;
        for (int r = 0; r < 4; r++) begin
            fill_source(1'b1);
            launch("rnd_shift", 8'($urandom));
            wait_done("rnd_done_seen", lat);
            check_output("rnd_latency_min", lat >= 41, 1);
            check_seq("rnd_seq");
            finish_load("rnd_busy_after");
        end
        gaps = 1'b0;

        repeat (3) apply_stimulus();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/consmax_lut_loader.md
Name: consmax_lut_loader

Overview:
- Initiator side of the ConSmax LUT-programming interface.
- Accepts packed LUT entries from the global bus via valid/ready. Unpacks each bus word into LUT_DATA-wide FP entries and issues sequential single-entry writes (lut_waddr/lut_wen/lut_wdata) covering both ConSmax LUT banks.
- Owns the cfg_consmax_shift register fed to consmax.
- Sits between the global-bus config path and consmax inside the vector-engine softmax wrapper.

Parameters:
- GBUS_DATA, 64, global bus data width; must be a multiple of LUT_DATA.
- IDATA_BIT, 8, consmax input width.
- EXP_BIT, 8, FP exponent bits.
- MAT_BIT, 7, FP mantissa bits.
- LUT_DATA, EXP_BIT+MAT_BIT+1 (16), LUT entry width.
- LUT_ADDR, IDATA_BIT>>1 (4), per-bank address width.
- LUT_DEPTH, 2**LUT_ADDR (16), entries per bank.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a load
- abort  input  1  cancel the load in progress
- cfg_shift_in  input  8  shift value latched on an accepted start
- in_data  input  GBUS_DATA  packed entries; lane 0 = bits [LUT_DATA-1:0]
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts in_data
- lut_waddr  output  LUT_ADDR+1  {bank, index}
- lut_wen  output  1  LUT write strobe
- lut_wdata  output  LUT_DATA  entry to write
- cfg_consmax_shift  output  8  registered shift value to consmax
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on completion

Behaviour:
- Single clock domain. Reset is synchronous, active-low, sampled on the clk rising edge.
- Derived constants:
  - K = GBUS_DATA/LUT_DATA entries per word (4).
  - TOTAL = 2*LUT_DEPTH entries (32).
  - Words per load = TOTAL/K (8).
- All outputs are registered.
- Reset values: in_ready=0, lut_wen=0, lut_waddr=0, lut_wdata=0, cfg_consmax_shift=0, busy=0, done=0. Internal entry counter=0, lane counter=0.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - start=1 latches cfg_shift_in into cfg_consmax_shift (visible next cycle), clears counters, moves to FETCH.
  - start in any other state is ignored.
- FETCH:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the word buffer, lane=0, move to WRITE.
  - in_ready drops the cycle after the accept; no second word is taken.
- WRITE:
  - One entry per cycle: lut_wen=1, lut_wdata=lane[lane], lut_waddr=entry counter (MSB = bank).
  - Entry counter and lane increment every WRITE cycle.
  - After lane K-1: if the entry counter has reached TOTAL-1, go to DONE; otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, lut_wen=0, then IDLE.
- Timing:
  - Each word costs 1 accept cycle plus K write cycles, with no overlap.
  - Minimum load time = 8*(1+4)+1 = 41 cycles after start.
  - Write order: bank 0 index 0..15, then bank 1 index 0..15.
  - lut_waddr never wraps within a load; the counter resets only on start, abort or reset.
- abort:
  - Takes priority over everything except rst_n.
  - From any non-IDLE state: next cycle state=IDLE, lut_wen=0, in_ready=0, done=0, counters cleared.
  - cfg_consmax_shift keeps its latched value.
  - abort in IDLE: no effect.
  - abort and start asserted together: abort wins; start is ignored.
- in_valid while in_ready=0: ignored, data not consumed. The upstream must hold it per valid/ready rules.
- rst_n low mid-load: everything returns to reset values the next edge. Partial LUT contents are not rolled back.

Optional Feature:
- Macro: CONSMAX_LUT_CHECKSUM_EN.
- With the macro:
  - Extra output port lut_checksum [LUT_DATA-1:0] holds the modulo-2^LUT_DATA sum of every lut_wdata written in the current load.
  - Cleared on start, abort and reset. Final value is valid while done=1 and held until the next start.
- Without the macro: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - LUT_DATA, LUT_ADDR, LUT_DEPTH derivations.
  - The FSM state enum {IDLE, FETCH, WRITE, DONE}.
  - Localparams K and TOTAL.
  - The FP entry typedef (sign/exp/mantissa).
- One natural sub-module: consmax_lut_unpack, the word buffer plus lane mux selecting entry[lane] from the captured GBUS word.

Test Plan:
- Nominal load: start, cfg_shift_in=0x05; 8 words with lane entry = 16'h3F00 + address; in_valid held high. Expect:
  - 32 writes, addr 0..31 in order, wdata 3F00..3F1F.
  - cfg_consmax_shift=0x05 from cycle after start.
  - done pulse at cycle 41; busy low after.
- Backpressure: in_valid low for 3 cycles before word 4. Expect in_ready held high in FETCH, no lut_wen during the stall, and an address sequence identical to the nominal load.
- Abort mid-load: abort while writing addr 13. Expect lut_wen=0 next cycle, busy=0, no done. A new start then begins again at addr 0.
- Start while busy: second start at addr 7 with cfg_shift_in=0x09. Expect it ignored and cfg_consmax_shift still 0x05.
- Reset mid-load: rst_n=0 for one cycle at addr 20. Expect all outputs 0 next edge and the FSM in IDLE.
- CONSMAX_LUT_CHECKSUM_EN: nominal load. Expect lut_checksum = sum(3F00..3F1F) mod 2^16 = 16'hE1F0 at done.
